fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/vga_pkg.sv | 20 ++
 rtl/fb_addr_calc.sv | 13 +
 rtl/fb_arbiter.sv | 159 +++++++++++++++
 tb/tb_fb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Timing and framebuffer constants shared by the pixel-memory arbiter and its helpers.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE   = 10'd640;
    localparam logic [9:0] H_TOTAL    = 10'd800;
    localparam logic [9:0] V_ACTIVE   = 10'd480;
    localparam logic [9:0] V_TOTAL    = 10'd525;
    localparam logic [7:0] FB_W       = 8'd160;
    localparam logic [6:0] FB_H       = 7'd120;
    localparam int         SCALE_LOG2 = 2;

    localparam int                ADDR_W       = 15;
    localparam logic [ADDR_W-1:0] FB_LAST_ADDR = 15'd19199;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Framebuffer address for a (row, col) pair: row*160 + col, built from shifts and adds only.
module fb_addr_calc
    import vga_pkg::*;
(
    input  logic [6:0]        row_i,
    input  logic [7:0]        col_i,
    output logic [ADDR_W-1:0] addr_o
);

    // row*160 = row*128 + row*32
    assign addr_o = {1'b0, row_i, 7'd0} + {3'b000, row_i, 5'd0} + {7'd0, col_i};

endmodule

// File: rtl/fb_arbiter.sv
// Shares one single-port pixel memory between display prefetch reads, draw writes and a
// full-framebuffer clear sweep; display reads always win.
module fb_arbiter #(
    parameter logic [9:0] H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter logic [9:0] H_TOTAL    = vga_pkg::H_TOTAL,
    parameter logic [9:0] V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter logic [9:0] V_TOTAL    = vga_pkg::V_TOTAL,
    parameter logic [7:0] FB_W       = vga_pkg::FB_W,
    parameter logic [6:0] FB_H       = vga_pkg::FB_H,
    parameter int         SCALE_LOG2 = vga_pkg::SCALE_LOG2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  vgaX,
    input  logic [9:0]  vgaY,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [7:0]  wr_data,
    input  logic        clear_req,
    input  logic [7:0]  clear_color,
    output logic        busy,
    output logic        clear_done,
    output logic [14:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pixel,
    output logic [7:0]  drop_count
);

    import vga_pkg::*;

    // Line slots fetch the block one ahead of the beam; the last one sits at vgaX=634.
    localparam logic [9:0] RD_X_END = H_ACTIVE - 10'd4;
    localparam logic [9:0] PRE_X    = H_TOTAL - 10'd2;
    localparam logic [9:0] V_LAST   = V_TOTAL - 10'd1;

    fb_state_t         state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [7:0]        clr_color_q;
    logic              clear_done_q;
    logic              rd_pend_q;
    logic [7:0]        prefetch_q;
    logic [7:0]        pixel_q;
    logic [7:0]        drop_q, drop_d;

    logic [9:0]        next_y;
    logic              slot_line, slot_pre, read_slot;
    logic              wr_fire, wr_in_range;
    logic [6:0]        calc_row;
    logic [7:0]        calc_col;
    logic [ADDR_W-1:0] calc_addr;

    assign next_y    = (vgaY == V_LAST) ? 10'd0 : vgaY + 10'd1;
    assign slot_line = (vgaX[1:0] == 2'b10) && (vgaX < RD_X_END) && (vgaY < V_ACTIVE);
    assign slot_pre  = (vgaX == PRE_X) && (next_y < V_ACTIVE);
    assign read_slot = slot_line | slot_pre;

    assign wr_ready    = (state_q == IDLE) && !clear_req && !read_slot;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (wr_x < FB_W) && (wr_y < FB_H);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        calc_row = wr_y;
        calc_col = wr_x;
        if (slot_line) begin
            calc_row = vgaY[SCALE_LOG2 +: 7];
            calc_col = vgaX[SCALE_LOG2 +: 8] + 8'd1;
        end else if (slot_pre) begin
            calc_row = next_y[SCALE_LOG2 +: 7];
            calc_col = 8'd0;
        end
    end

    fb_addr_calc u_addr_calc (
        .row_i  (calc_row),
        .col_i  (calc_col),
        .addr_o (calc_addr)
    );

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (read_slot) begin
            mem_re   = 1'b1;
            mem_addr = calc_addr;
        end else if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr_q;
            mem_wdata = clr_color_q;
        end else if (wr_fire && wr_in_range) begin
            mem_we    = 1'b1;
            mem_addr  = calc_addr;
            mem_wdata = wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            clr_color_q  <= 8'h00;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q     <= CLEAR;
                        clr_addr_q  <= '0;
                        clr_color_q <= clear_color;
                    end
                end
                CLEAR: begin
                    if (!read_slot) begin
                        if (clr_addr_q == FB_LAST_ADDR) begin
                            state_q      <= IDLE;
                            clear_done_q <= 1'b1;
                        end else begin
                            clr_addr_q <= clr_addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drop_d = (wr_fire && !wr_in_range && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q  <= 1'b0;
            prefetch_q <= 8'h00;
            pixel_q    <= 8'h00;
            drop_q     <= 8'h00;
        end else begin
            rd_pend_q <= read_slot;
            if (rd_pend_q) begin
                prefetch_q <= mem_rdata;
            end
            pixel_q <= ((vgaX < H_ACTIVE) && (vgaY < V_ACTIVE)) ? prefetch_q : 8'h00;
            drop_q  <= drop_d;
        end
    end

    assign busy       = (state_q == CLEAR);
    assign clear_done = clear_done_q;
    assign pixel      = pixel_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomised bench for fb_arbiter: a spec-level model predicts every memory-port and output value.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  vgaX, vgaY;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [7:0]  wr_data;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        busy, clear_done;
    logic [14:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  pixel, drop_count;
    logic        preload;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .vgaX        (vgaX),
        .vgaY        (vgaY),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .busy        (busy),
        .clear_done  (clear_done),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pixel       (pixel),
        .drop_count  (drop_count)
    );

    function automatic logic [7:0] pat(int i);
        return 8'((i * 73) ^ (i >> 5));
    endfunction

    // Pixel memory seen by the DUT: registered read, rdata holds while mem_re is low.
    logic [7:0] env_mem [0:19199];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 19200; i++) env_mem[i] <= pat(i);
        end else begin
            if (mem_we && mem_addr < 15'd19200) env_mem[mem_addr] <= mem_wdata;
            if (mem_re && mem_addr < 15'd19200) mem_rdata <= env_mem[mem_addr];
        end
    end

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0] m_mem [0:19199];
    bit         m_busy, m_done, m_pend;
    int         m_idx, m_drop;
    logic [7:0] m_color, m_pref, m_pixel, m_rd;

    int dut_done_cnt  = 0;
    int clr_seq       = 0;
    int clr_order_err = 0;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_pend = 0;
        m_idx = 0; m_drop = 0;
        m_color = 8'h00; m_pref = 8'h00; m_pixel = 8'h00;
    endtask

    // One clock: predict and compare mid-cycle, then advance the model across the edge.
    task automatic tick();
        int  x = int'(vgaX);
        int  y = int'(vgaY);
        int  ny = (y == 524) ? 0 : y + 1;
        bit  rs_a = (x % 4 == 2) && (x < 636) && (y < 480);
        bit  rs_b = (x == 798) && (ny < 480);
        bit  rs = rs_a || rs_b;
        int  raddr = rs_a ? (y / 4) * 160 + x / 4 + 1 : (ny / 4) * 160;
        bit  rdy = !m_busy && !clear_req && !rs;
        bit  fire = wr_valid && rdy;
        bit  inr = (int'(wr_x) < 160) && (int'(wr_y) < 120);
        bit  e_we = !rs && (m_busy || (fire && inr));
        int  e_addr = rs ? raddr : m_busy ? m_idx : (fire && inr) ? int'(wr_y) * 160 + int'(wr_x) : 0;
        logic [7:0]  e_wd = rs ? 8'h00 : m_busy ? m_color : (fire && inr) ? wr_data : 8'h00;
        logic [14:0] e_a15 = 15'(e_addr);
        #4;
        check("memif", {6'd0, mem_re, mem_we, mem_addr, mem_wdata, wr_ready},
              {6'd0, rs, e_we, e_a15, e_wd, rdy});
        check("outputs", {14'd0, busy, clear_done, pixel, drop_count},
              {14'd0, m_busy, m_done, m_pixel, 8'(m_drop)});
        if (clear_done) dut_done_cnt++;
        if (busy && mem_we) begin
            if (int'(mem_addr) != clr_seq) clr_order_err++;
            clr_seq++;
        end
        @(posedge clk);
        m_pixel = (x < 640 && y < 480) ? m_pref : 8'h00;
        if (m_pend) m_pref = m_rd;
        m_pend = rs;
        if (rs) m_rd = m_mem[raddr];
        if (e_we) m_mem[e_addr] = e_wd;
        m_done = 0;
        if (!m_busy) begin
            if (clear_req) begin
                m_busy = 1; m_idx = 0; m_color = clear_color;
            end
        end else if (!rs) begin
            if (m_idx == 19199) begin
                m_busy = 0; m_done = 1;
            end else begin
                m_idx++;
            end
        end
        if (fire && !inr && m_drop < 255) m_drop++;
        #1;
    endtask

    task automatic scan_step();
        if (vgaX == 10'd799) begin
            vgaX = 10'd0;
            vgaY = (vgaY == 10'd524) ? 10'd0 : vgaY + 10'd1;
        end else begin
            vgaX = vgaX + 10'd1;
        end
    endtask

    task automatic do_reset_midcycle();
        vgaX = 10'd700; wr_valid = 1'b0; clear_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pixel", {24'd0, pixel}, 32'd0);
        check("rst_drop", {24'd0, drop_count}, 32'd0);
        check("rst_done", {31'd0, clear_done}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic probe(input int x, input int y, input bit re, input int addr);
        vgaX = 10'(x); vgaY = 10'(y);
        #1;
        check($sformatf("probe_re_%0d_%0d", x, y), {31'd0, mem_re}, {31'd0, re});
        if (re) check($sformatf("probe_addr_%0d_%0d", x, y), {17'd0, mem_addr}, 32'(addr));
        check($sformatf("probe_rdy_%0d_%0d", x, y), {31'd0, wr_ready}, {31'd0, !re});
        tick();
    endtask

    task automatic direct_write(input int x, input int y, input logic [7:0] d);
        vgaX = 10'd700; vgaY = 10'd8;
        wr_valid = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        int bad;
        vgaX = 10'd700; vgaY = 10'd8;
        wr_valid = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_data = 8'h00;
        clear_req = 1'b0; clear_color = 8'h00;
        preload = 1'b1;
        for (int i = 0; i < 19200; i++) m_mem[i] = pat(i);
        m_rd = 8'h00;
        model_reset();
        @(posedge clk);
        #1 preload = 1'b0;
        do_reset_midcycle();

        // Read-slot placement and address mapping.
        wr_valid = 1'b0;
        probe(2, 8, 1, 321);
        probe(798, 7, 1, 320);
        probe(798, 524, 1, 0);
        probe(798, 479, 0, 0);
        probe(634, 100, 1, 25 * 160 + 159);
        probe(638, 100, 0, 0);

        // Draw writes in and out of range.
        vgaX = 10'd700; vgaY = 10'd8;
        wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_data = 8'hE0;
        #1;
        check("wr_we", {31'd0, mem_we}, 32'd1);
        check("wr_addr_5_3", {17'd0, mem_addr}, 32'd485);
        check("wr_wdata", {24'd0, mem_wdata}, 32'hE0);
        tick();
        wr_x = 8'd3; wr_y = 7'd3;
        #1;
        check("wr_addr_3_3", {17'd0, mem_addr}, 32'd483);
        tick();
        wr_x = 8'd160; wr_y = 7'd3;
        #1;
        check("oor_ready", {31'd0, wr_ready}, 32'd1);
        check("oor_we", {31'd0, mem_we}, 32'd0);
        tick();
        wr_valid = 1'b0;
        check("drop_one", {24'd0, drop_count}, 32'd1);

        // Prefetch into pixel along scan line 8.
        direct_write(1, 2, 8'h1C);
        vgaX = 10'd0; vgaY = 10'd8;
        for (int n = 0; n < 700; n++) begin
            int px = int'(vgaX);
            tick();
            if (px >= 4 && px <= 7) check("pix_line8", {24'd0, pixel}, 32'h1C);
            if (px >= 640 && px < 648) check("pix_blank", {24'd0, pixel}, 32'd0);
            scan_step();
        end

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            int r = int'($urandom_range(0, 15));
            if (r == 0) begin
                vgaX = 10'($urandom_range(0, 799)); vgaY = 10'($urandom_range(0, 524));
            end else if (r == 1) begin
                vgaX = 10'd798; vgaY = 10'($urandom_range(0, 3) == 0 ? 478 : $urandom_range(0, 3) == 0 ? 479 : $urandom_range(0, 1) == 0 ? 523 : 524);
            end else begin
                scan_step();
            end
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = 8'($urandom_range(0, 175));
            wr_y = 7'($urandom_range(0, 127));
            wr_data = 8'($urandom);
            tick();
        end
        wr_valid = 1'b0;

        // Drop counter saturation.
        vgaX = 10'd700; vgaY = 10'd8;
        wr_valid = 1'b1; wr_x = 8'd200; wr_y = 7'd10;
        for (int n = 0; n < 300; n++) tick();
        wr_valid = 1'b0;
        check("drop_sat", {24'd0, drop_count}, 32'd255);

        // Clear requested alongside a write: write refused, sweep covers the whole buffer.
        vgaX = 10'd0; vgaY = 10'd0;
        clear_req = 1'b1; clear_color = 8'h03;
        wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd5; wr_data = 8'hAA;
        #1;
        check("clr_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("clr_wr_we", {31'd0, mem_we}, 32'd0);
        dut_done_cnt = 0; clr_seq = 0; clr_order_err = 0;
        tick();
        clear_req = 1'b0; clear_color = 8'h77;
        check("clr_busy", {31'd0, busy}, 32'd1);
        for (int n = 0; n < 30000 && dut_done_cnt == 0; n++) begin
            scan_step();
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = 8'($urandom_range(0, 159));
            wr_y = 7'($urandom_range(0, 119));
            clear_req = 1'($urandom_range(0, 7) == 0);
            if (dut.busy) tick(); else begin clear_req = 1'b0; tick(); end
        end
        clear_req = 1'b0; wr_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin scan_step(); tick(); end
        check("clr_done_pulses", 32'(dut_done_cnt), 32'd1);
        check("clr_write_count", 32'(clr_seq), 32'd19200);
        check("clr_order", 32'(clr_order_err), 32'd0);
        check("clr_busy_end", {31'd0, busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 19200; i++) if (env_mem[i] !== 8'h03) bad++;
        check("clr_fill", 32'(bad), 32'd0);

        // Reset in the middle of a sweep abandons it.
        vgaX = 10'd0; vgaY = 10'd0;
        clear_req = 1'b1; clear_color = 8'h55;
        tick();
        clear_req = 1'b0;
        dut_done_cnt = 0;
        for (int n = 0; n < 10000 && m_idx != 5000; n++) begin
            scan_step();
            tick();
        end
        check("rst_at_5000", 32'(m_idx), 32'd5000);
        do_reset_midcycle();
        for (int n = 0; n < 200; n++) begin scan_step(); tick(); end
        check("rst_no_done", 32'(dut_done_cnt), 32'd0);
        check("rst_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
